// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the boot copier: data width and FSM state encoding.
package wb_pkg;

    localparam int WB_DW = 32;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_WAIT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/wb_req_hold.sv
// Request-side drive of the Wishbone master: stb/we/addr/data straight from FSM state and registers.
// Zero latency; under stall the request is held because the FSM stays put and its registers are frozen.
module wb_req_hold
    import wb_pkg::*;
#(
    parameter int AW = 7
) (
    input  logic             rd_req_i,
    input  logic             wr_req_i,
    input  logic [AW-1:0]    src_i,
    input  logic [AW-1:0]    dst_i,
    input  logic [WB_DW-1:0] wdat_i,
    input  logic             stall_i,
    output logic             stb_o,
    output logic             we_o,
    output logic [AW-1:0]    addr_o,
    output logic [WB_DW-1:0] data_o,
    output logic             acc_o
);

    always_comb begin
        stb_o  = rd_req_i | wr_req_i;
        we_o   = wr_req_i;
        addr_o = '0;
        if (wr_req_i) begin
            addr_o = dst_i;
        end else if (rd_req_i) begin
            addr_o = src_i;
        end
        data_o = wdat_i;
        acc_o  = stb_o & ~stall_i;
    end

endmodule

// File: rtl/wb_boot_copier.sv
// Wishbone pipelined master copying LEN words src->dst, one transaction outstanding (4 cycles/word unstalled).
// Stall holds the request indefinitely; a missing ack aborts after TIMEOUT wait cycles with o_err set.
module wb_boot_copier
    import wb_pkg::*;
#(
    parameter int AW      = 7,
    parameter int LENW    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic [AW-1:0]    i_src,
    input  logic [AW-1:0]    i_dst,
    input  logic [LENW-1:0]  i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_wb_cyc,
    output logic             o_wb_stb,
    output logic             o_wb_we,
    output logic [AW-1:0]    o_wb_addr,
    output logic [WB_DW-1:0] o_wb_data,
    input  logic             i_wb_ack,
    input  logic             i_wb_stall,
    input  logic [WB_DW-1:0] i_wb_data
);

    // Counter only needs to reach TIMEOUT-1: the abort fires on that wait cycle.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            state_q, state_d;
    logic [AW-1:0]     src_q, src_d;
    logic [AW-1:0]     dst_q, dst_d;
    logic [LENW-1:0]   rem_q, rem_d;
    logic [WB_DW-1:0]  wdat_q, wdat_d;
    logic              err_q, err_d;
    logic [TW-1:0]     tmo_q, tmo_d;

    logic              req_acc;
    logic              tmo_hit;

    assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1));

    wb_req_hold #(.AW(AW)) u_req_hold (
        .rd_req_i (state_q == S_RD_REQ),
        .wr_req_i (state_q == S_WR_REQ),
        .src_i    (src_q),
        .dst_i    (dst_q),
        .wdat_i   (wdat_q),
        .stall_i  (i_wb_stall),
        .stb_o    (o_wb_stb),
        .we_o     (o_wb_we),
        .addr_o   (o_wb_addr),
        .data_o   (o_wb_data),
        .acc_o    (req_acc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            wdat_q  <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            wdat_q  <= wdat_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        wdat_d  = wdat_q;
        err_d   = err_q;
        tmo_d   = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    src_d   = i_src;
                    dst_d   = i_dst;
                    rem_d   = i_len;
                    err_d   = 1'b0;
                    state_d = (i_len == '0) ? S_DONE : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (req_acc) begin
                    tmo_d   = '0;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (i_wb_ack) begin
                    wdat_d  = i_wb_data;
                    state_d = S_WR_REQ;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WR_REQ: begin
                if (req_acc) begin
                    tmo_d   = '0;
                    state_d = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (i_wb_ack) begin
                    src_d   = src_q + 1'b1;
                    dst_d   = dst_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == LENW'(1)) ? S_DONE : S_RD_REQ;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state register so reset drops cyc/stb without waiting for a clock.
    always_comb begin
        o_wb_cyc = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT) ||
                   (state_q == S_WR_REQ) || (state_q == S_WR_WAIT);
        o_busy   = o_wb_cyc;
        o_done   = (state_q == S_DONE);
        o_err    = err_q;
    end

endmodule

// File: tb/tb_wb_boot_copier.sv
// Directed bench: wb_boot_copier against a single 128-word Wishbone memory model with registered ack.
module tb_wb_boot_copier;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_start;
    logic [6:0]  i_src;
    logic [6:0]  i_dst;
    logic [7:0]  i_len;
    logic        o_busy, o_done, o_err;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [6:0]  o_wb_addr;
    logic [31:0] o_wb_data;
    logic        i_wb_ack;
    logic        i_wb_stall;
    logic [31:0] i_wb_data;

    int total = 0;
    int bad   = 0;

    // memory / slave model state
    logic [31:0] mem [0:127];
    logic [6:0]  rd_log [0:63];
    int          rd_n      = 0;
    int          stall_cnt = 0;
    int          stall_at  = -1;
    logic        stall_en  = 1'b0;
    logic        drop_wr   = 1'b0;
    logic        preload   = 1'b0;
    logic        ack_q     = 1'b0;
    logic [31:0] rdat_q    = '0;

    always #5 clk = ~clk;

    wb_boot_copier #(.AW(7), .LENW(8), .TIMEOUT(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_start    (i_start),
        .i_src      (i_src),
        .i_dst      (i_dst),
        .i_len      (i_len),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_addr  (o_wb_addr),
        .o_wb_data  (o_wb_data),
        .i_wb_ack   (i_wb_ack),
        .i_wb_stall (i_wb_stall),
        .i_wb_data  (i_wb_data)
    );

    assign i_wb_ack   = ack_q;
    assign i_wb_data  = rdat_q;
    assign i_wb_stall = stall_en && o_wb_cyc && o_wb_stb && !o_wb_we &&
                        (rd_n == stall_at) && (stall_cnt < 3);

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h11111111 * (i + 1);
            ack_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
                if (o_wb_we) begin
                    if (!drop_wr) begin
                        mem[o_wb_addr] <= o_wb_data;
                        ack_q <= 1'b1;
                    end
                end else begin
                    rdat_q <= mem[o_wb_addr];
                    ack_q  <= 1'b1;
                    rd_log[rd_n[5:0]] <= o_wb_addr;
                    rd_n <= rd_n + 1;
                end
            end
            if (i_wb_stall) stall_cnt <= stall_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [6:0] s, input logic [6:0] d, input logic [7:0] l);
        @(posedge clk); #1;
        i_start = 1'b1; i_src = s; i_dst = d; i_len = l;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    // n = cycle index in which o_done is seen, counting the start cycle as 0
    task automatic run_copy(input logic [6:0] s, input logic [6:0] d, input logic [7:0] l,
                            input int pulse_at, output int n, output bit cyc_seen, output int stalls);
        bit got;
        got = 1'b0; cyc_seen = 1'b0; stalls = 0;
        pulse_start(s, d, l);
        n = 1;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (n == 1) begin
                chk("busy_c1", 64'(o_busy), 64'(l != 8'd0));
                chk("err_clr_c1", 64'(o_err), 64'd0);
            end
            if (o_wb_cyc) cyc_seen = 1'b1;
            if (i_wb_stall) begin
                stalls++;
                chk("stall_hold", {o_wb_stb, o_wb_we, o_wb_addr}, {1'b1, 1'b0, 7'(s + 7'd1)});
            end
            if (o_done) begin
                got = 1'b1;
            end else begin
                @(posedge clk); #1;
                n++;
                if (n == pulse_at) begin
                    i_start = 1'b1; i_src = 7'h01; i_dst = 7'h70; i_len = 8'd5;
                end else begin
                    i_start = 1'b0;
                end
            end
        end
        if (!got) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int  n, st, base;
        bit  cs;
        logic [31:0] snap;

        reset_n = 1'b0;
        i_start = 1'b0; i_src = '0; i_dst = '0; i_len = '0;
        preload = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", {o_wb_cyc, o_wb_stb, o_wb_we, o_busy, o_done, o_err}, 6'b0);
        chk("rst_addr", 64'(o_wb_addr), 64'd0);
        chk("rst_data", 64'(o_wb_data), 64'd0);
        preload = 1'b0;
        reset_n = 1'b1;

        // 1) basic 4-word copy
        run_copy(7'h00, 7'h40, 8'd4, -1, n, cs, st);
        chk("t1_done_cycle", 64'(n), 64'd17);
        chk("t1_cyc_seen", 64'(cs), 64'd1);
        chk("t1_w0", 64'(mem[7'h40]), 64'h11111111);
        chk("t1_w1", 64'(mem[7'h41]), 64'h22222222);
        chk("t1_w2", 64'(mem[7'h42]), 64'h33333333);
        chk("t1_w3", 64'(mem[7'h43]), 64'h44444444);
        chk("t1_err", 64'(o_err), 64'd0);

        // 2) zero length: no bus cycles
        base = rd_n;
        run_copy(7'h05, 7'h44, 8'd0, -1, n, cs, st);
        chk("t2_done_cycle", 64'(n), 64'd1);
        chk("t2_no_cyc", 64'(cs), 64'd0);
        chk("t2_err", 64'(o_err), 64'd0);
        chk("t2_no_reads", 64'(rd_n - base), 64'd0);
        chk("t2_dst_untouched", 64'(mem[7'h44]), 64'h99999995);

        // 3) three stall cycles on the second read
        stall_at = rd_n + 1;
        stall_en = 1'b1;
        run_copy(7'h10, 7'h48, 8'd3, -1, n, cs, st);
        stall_en = 1'b0;
        chk("t3_stalls", 64'(st), 64'd3);
        chk("t3_done_cycle", 64'(n), 64'd16);
        chk("t3_w0", 64'(mem[7'h48]), 64'h22222221);
        chk("t3_w1", 64'(mem[7'h49]), 64'h33333332);
        chk("t3_w2", 64'(mem[7'h4A]), 64'h44444443);

        // 4) first write never acked -> timeout abort
        drop_wr = 1'b1;
        snap = mem[7'h60];
        run_copy(7'h20, 7'h60, 8'd2, -1, n, cs, st);
        chk("t4_err", 64'(o_err), 64'd1);
        chk("t4_cyc_low", {o_wb_cyc, o_wb_stb}, 2'b00);
        chk("t4_captured", 64'(o_wb_data), 64'h33333331);
        chk("t4_ram_unchanged", 64'(mem[7'h60]), 64'h77777771);
        chk("t4_ram_snap", 64'(mem[7'h60]), 64'(snap));
        @(negedge clk);
        chk("t4_err_sticky", {o_err, o_done, o_busy}, 3'b100);
        drop_wr = 1'b0;

        // 5) address wrap, with an ignored start mid-copy
        base = rd_n;
        run_copy(7'h7E, 7'h50, 8'd3, 6, n, cs, st);
        chk("t5_done_cycle", 64'(n), 64'd13);
        chk("t5_nreads", 64'(rd_n - base), 64'd3);
        chk("t5_rd0", 64'(rd_log[6'(base)]), 64'h7E);
        chk("t5_rd1", 64'(rd_log[6'(base + 1)]), 64'h7F);
        chk("t5_rd2", 64'(rd_log[6'(base + 2)]), 64'h00);
        chk("t5_w0", 64'(mem[7'h50]), 64'h7777776F);
        chk("t5_w1", 64'(mem[7'h51]), 64'h88888880);
        chk("t5_w2", 64'(mem[7'h52]), 64'h11111111);
        chk("t5_ignored_dst", 64'(mem[7'h70]), 64'h88888881);
        @(negedge clk);
        chk("t5_idle", {o_busy, o_done}, 2'b00);

        // 6) reset during WR_WAIT of the first word, then a fresh copy
        pulse_start(7'h30, 7'h58, 8'd4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_in_wr_wait", {o_wb_cyc, o_wb_stb, o_busy}, 3'b101);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_async_drop", {o_wb_cyc, o_wb_stb, o_busy, o_done}, 4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_copy(7'h34, 7'h5C, 8'd2, -1, n, cs, st);
        chk("t6_done_cycle", 64'(n), 64'd9);
        chk("t6_w0", 64'(mem[7'h5C]), 64'h88888885);
        chk("t6_w1", 64'(mem[7'h5D]), 64'h99999996);
        chk("t6_err", 64'(o_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
